cache_data_bank: RTL and testbench

Parametrised data array for the L1 caches: SETS × WAYS lines of WORDS 32-bit words, with a byte-strobed store port, a registered single-word load port, a registered whole-line victim port, and an internal refill sequencer. The refill sequencer writes a line streamed one word per beat from the AXI bridge. It sits beside the tag/valid array inside the cache controller. It replaces the fixed 4-word, word-write-only data array and adds byte strobes, a line refill FSM and configurable geometry.

---
 rtl/cache_data_bank_if.sv | 62 ++++++
 rtl/cache_data_bank.sv | 152 +++++++++++++++
 tb/tb_cache_data_bank.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_data_bank_if.sv
// cache_data_bank_if: load, store, victim and refill ports of the L1 data bank.
// The master side is the cache controller. The slave side is cache_data_bank.
interface cache_data_bank_if #(
   parameter int SETS  = 256,
   parameter int WAYS  = 2,
   parameter int WORDS = 4
);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int OFF_W = $clog2(WORDS);

   // load port
   logic             rd_en;
   logic [IDX_W-1:0] rd_index;
   logic [WAY_W-1:0] rd_way;
   logic [OFF_W-1:0] rd_offset;
   logic [31:0]      rd_data;
   logic             rd_valid;

   // store port
   logic             wr_en;
   logic [IDX_W-1:0] wr_index;
   logic [WAY_W-1:0] wr_way;
   logic [OFF_W-1:0] wr_offset;
   logic [3:0]       wr_strb;
   logic [31:0]      wr_data;
   logic             wr_ready;

   // victim port
   logic               vict_req;
   logic [IDX_W-1:0]   vict_index;
   logic [WAY_W-1:0]   vict_way;
   logic [WORDS*32-1:0] vict_line;
   logic               vict_valid;

   // refill port
   logic             refill_start;
   logic [IDX_W-1:0] refill_index;
   logic [WAY_W-1:0] refill_way;
   logic             refill_valid;
   logic [31:0]      refill_data;
   logic             refill_busy;
   logic             refill_done;

   modport master (
      output rd_en, rd_index, rd_way, rd_offset,
      output wr_en, wr_index, wr_way, wr_offset, wr_strb, wr_data,
      output vict_req, vict_index, vict_way,
      output refill_start, refill_index, refill_way, refill_valid, refill_data,
      input  rd_data, rd_valid, wr_ready, vict_line, vict_valid,
      input  refill_busy, refill_done
   );

   modport slave (
      input  rd_en, rd_index, rd_way, rd_offset,
      input  wr_en, wr_index, wr_way, wr_offset, wr_strb, wr_data,
      input  vict_req, vict_index, vict_way,
      input  refill_start, refill_index, refill_way, refill_valid, refill_data,
      output rd_data, rd_valid, wr_ready, vict_line, vict_valid,
      output refill_busy, refill_done
   );
endinterface

// File: rtl/cache_data_bank.sv
// cache_data_bank: SETS x WAYS lines of WORDS 32-bit words for the L1 caches.
// Byte-strobed store, registered load and whole-line victim reads, and a
// refill sequencer that writes a line streamed one word per beat.
// Optional macro DATA_BANK_FWD_EN: write-first forwarding when a load or victim
// read hits the word written in the same cycle; without it reads are read-first.
module cache_data_bank #(
   parameter int SETS  = 256,
   parameter int WAYS  = 2,
   parameter int WORDS = 4
) (
   input logic              clk,
   input logic              resetn,
   cache_data_bank_if.slave bus
);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int OFF_W = $clog2(WORDS);
   localparam int ADR_W = IDX_W + WAY_W + OFF_W;
   localparam int DEPTH = SETS * WAYS * WORDS;

   typedef enum logic {ST_IDLE, ST_REFILL} state_t;

   state_t           state;
   logic [IDX_W-1:0] rf_index;
   logic [WAY_W-1:0] rf_way;
   logic [OFF_W-1:0] rf_cnt;

   logic [31:0] mem [DEPTH];

   logic             we;
   logic [ADR_W-1:0] waddr;
   logic [31:0]      wdata;
   logic [3:0]       wstrb;

   logic [ADR_W-1:0]    raddr;
   logic [31:0]         rd_word;
   logic [WORDS*32-1:0] vict_word;

`ifdef DATA_BANK_FWD_EN
   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  strb);
      logic [31:0] r;
      r = old_w;
      for (int unsigned b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction
`endif

   // Single write port: refill beats own it in REFILL, stores own it in IDLE.
   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      wstrb = '0;
      if (state == ST_REFILL) begin
         if (bus.refill_valid) begin
            we    = 1'b1;
            waddr = {rf_index, rf_way, rf_cnt};
            wdata = bus.refill_data;
            wstrb = '1;
         end
      end else if (bus.wr_en) begin
         we    = 1'b1;
         waddr = {bus.wr_index, bus.wr_way, bus.wr_offset};
         wdata = bus.wr_data;
         wstrb = bus.wr_strb;
      end
   end

   // Byte-masked array write; contents are left untouched by reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned b = 0; b < 4; b++)
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   // Data presented to the load and victim output registers.
   always_comb begin
      raddr     = {bus.rd_index, bus.rd_way, bus.rd_offset};
      rd_word   = mem[raddr];
      vict_word = '0;
`ifdef DATA_BANK_FWD_EN
      if (we && (waddr == raddr)) rd_word = merge(rd_word, wdata, wstrb);
`endif
      for (int unsigned w = 0; w < WORDS; w++) begin
         vict_word[32*w +: 32] = mem[{bus.vict_index, bus.vict_way, OFF_W'(w)}];
`ifdef DATA_BANK_FWD_EN
         if (we && (waddr == {bus.vict_index, bus.vict_way, OFF_W'(w)}))
            vict_word[32*w +: 32] = merge(vict_word[32*w +: 32], wdata, wstrb);
`endif
      end
   end

   // Registered load and victim ports; data holds when not requested.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.rd_data    <= '0;
         bus.rd_valid   <= 1'b0;
         bus.vict_line  <= '0;
         bus.vict_valid <= 1'b0;
      end else begin
         bus.rd_valid   <= bus.rd_en;
         bus.vict_valid <= bus.vict_req;
         if (bus.rd_en)    bus.rd_data   <= rd_word;
         if (bus.vict_req) bus.vict_line <= vict_word;
      end
   end

   // Refill sequencer with registered busy/done/ready status.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= ST_IDLE;
         rf_index        <= '0;
         rf_way          <= '0;
         rf_cnt          <= '0;
         bus.refill_busy <= 1'b0;
         bus.refill_done <= 1'b0;
         bus.wr_ready    <= 1'b1;
      end else begin
         bus.refill_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.refill_start) begin
                  state           <= ST_REFILL;
                  rf_index        <= bus.refill_index;
                  rf_way          <= bus.refill_way;
                  rf_cnt          <= '0;
                  bus.refill_busy <= 1'b1;
                  bus.wr_ready    <= 1'b0;
               end
            end
            ST_REFILL: begin
               if (bus.refill_valid) begin
                  if (rf_cnt == OFF_W'(WORDS - 1)) begin
                     state           <= ST_IDLE;
                     rf_cnt          <= '0;
                     bus.refill_busy <= 1'b0;
                     bus.refill_done <= 1'b1;
                     bus.wr_ready    <= 1'b1;
                  end else begin
                     rf_cnt <= rf_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_data_bank.sv
// tb_cache_data_bank: self-checking bench for cache_data_bank, default geometry
// plus a SETS=4/WAYS=4/WORDS=8 instance. Expected data comes from a flat word
// array model updated with the byte-strobe and refill rules.
module tb_cache_data_bank;
   localparam int SETS = 256, WAYS = 2, WORDS = 4;
   localparam int M_IDX_W = $clog2(SETS), M_WAY_W = $clog2(WAYS), M_OFF_W = $clog2(WORDS);
   localparam int G_SETS = 4, G_WAYS = 4, G_WORDS = 8;
   localparam int G_IDX_W = $clog2(G_SETS), G_WAY_W = $clog2(G_WAYS);
`ifdef DATA_BANK_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   cache_data_bank_if #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) m_if ();
   cache_data_bank_if #(.SETS(G_SETS), .WAYS(G_WAYS), .WORDS(G_WORDS)) g_if ();

   cache_data_bank #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) u_dut (
      .clk(clk), .resetn(resetn), .bus(m_if));
   cache_data_bank #(.SETS(G_SETS), .WAYS(G_WAYS), .WORDS(G_WORDS)) u_geo (
      .clk(clk), .resetn(resetn), .bus(g_if));

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] ref_mem [SETS*WAYS*WORDS];
   logic [31:0] last_rd;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int lin(input int s, input int w, input int o);
      return (s * WAYS + w) * WORDS + o;
   endfunction

   function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_idle();
      m_if.rd_en = 0; m_if.rd_index = '0; m_if.rd_way = '0; m_if.rd_offset = '0;
      m_if.wr_en = 0; m_if.wr_index = '0; m_if.wr_way = '0; m_if.wr_offset = '0;
      m_if.wr_strb = '0; m_if.wr_data = '0;
      m_if.vict_req = 0; m_if.vict_index = '0; m_if.vict_way = '0;
      m_if.refill_start = 0; m_if.refill_index = '0; m_if.refill_way = '0;
      m_if.refill_valid = 0; m_if.refill_data = '0;
   endtask

   task automatic set_wr(input int s, input int w, input int o, input logic [3:0] strb,
                         input logic [31:0] d);
      m_if.wr_en = 1; m_if.wr_index = M_IDX_W'(s); m_if.wr_way = M_WAY_W'(w);
      m_if.wr_offset = M_OFF_W'(o); m_if.wr_strb = strb; m_if.wr_data = d;
   endtask

   task automatic set_rd(input int s, input int w, input int o);
      m_if.rd_en = 1; m_if.rd_index = M_IDX_W'(s); m_if.rd_way = M_WAY_W'(w);
      m_if.rd_offset = M_OFF_W'(o);
   endtask

   task automatic write_word(input int s, input int w, input int o, input logic [31:0] d);
      set_wr(s, w, o, 4'hF, d);
      tick();
      m_if.wr_en = 0;
      ref_mem[lin(s, w, o)] = d;
   endtask

   task automatic read_check(input string tag, input int s, input int w, input int o);
      set_rd(s, w, o);
      tick();
      m_if.rd_en = 0;
      check(tag, m_if.rd_data, ref_mem[lin(s, w, o)]);
      check({tag, "_valid"}, m_if.rd_valid, 1'b1);
   endtask

   function automatic logic [255:0] model_line(input int s, input int w);
      logic [255:0] e = '0;
      for (int k = 0; k < WORDS; k++) e[32*k +: 32] = ref_mem[lin(s, w, k)];
      return e;
   endfunction

   task automatic vict_check(input string tag, input int s, input int w);
      m_if.vict_req = 1; m_if.vict_index = M_IDX_W'(s); m_if.vict_way = M_WAY_W'(w);
      tick();
      m_if.vict_req = 0;
      check(tag, m_if.vict_line, model_line(s, w));
      check({tag, "_valid"}, m_if.vict_valid, 1'b1);
   endtask

   task automatic refill_line(input int s, input int w, input logic [31:0] base);
      m_if.refill_start = 1; m_if.refill_index = M_IDX_W'(s); m_if.refill_way = M_WAY_W'(w);
      tick();
      m_if.refill_start = 0;
      check("rf_busy_rise", m_if.refill_busy, 1'b1);
      check("rf_wr_ready_low", m_if.wr_ready, 1'b0);
      for (int k = 0; k < WORDS; k++) begin
         m_if.refill_valid = 1; m_if.refill_data = base + 32'(k);
         tick();
         ref_mem[lin(s, w, k)] = base + 32'(k);
         check("rf_done", m_if.refill_done, k == WORDS - 1);
         check("rf_busy", m_if.refill_busy, k != WORDS - 1);
      end
      m_if.refill_valid = 0;
      tick();
      check("rf_done_pulse", m_if.refill_done, 1'b0);
      vict_check("rf_line", s, w);
   endtask

   initial begin
      logic [31:0] exp_rd;
      logic [255:0] exp_v;
      int beat;

      m_idle();
      g_if.rd_en = 0; g_if.rd_index = '0; g_if.rd_way = '0; g_if.rd_offset = '0;
      g_if.wr_en = 0; g_if.wr_index = '0; g_if.wr_way = '0; g_if.wr_offset = '0;
      g_if.wr_strb = '0; g_if.wr_data = '0;
      g_if.vict_req = 0; g_if.vict_index = '0; g_if.vict_way = '0;
      g_if.refill_start = 0; g_if.refill_index = '0; g_if.refill_way = '0;
      g_if.refill_valid = 0; g_if.refill_data = '0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_data", m_if.rd_data, 32'h0);
      check("rst_rd_valid", m_if.rd_valid, 1'b0);
      check("rst_vict_line", m_if.vict_line, '0);
      check("rst_vict_valid", m_if.vict_valid, 1'b0);
      check("rst_busy", m_if.refill_busy, 1'b0);
      check("rst_done", m_if.refill_done, 1'b0);
      resetn = 1;
      tick();
      check("rst_wr_ready", m_if.wr_ready, 1'b1);

      // byte-strobed store
      write_word(5, 1, 2, 32'h11223344);
      set_wr(5, 1, 2, 4'b0101, 32'hAABBCCDD);
      tick();
      m_if.wr_en = 0;
      ref_mem[lin(5, 1, 2)] = apply_strb(ref_mem[lin(5, 1, 2)], 32'hAABBCCDD, 4'b0101);
      set_rd(5, 1, 2);
      tick();
      m_if.rd_en = 0;
      check("byte_store", m_if.rd_data, 32'h11BB33DD);
      check("byte_store_valid", m_if.rd_valid, 1'b1);
      set_wr(5, 1, 2, 4'b0000, 32'h0);
      tick();
      m_if.wr_en = 0;
      check("rd_valid_drop", m_if.rd_valid, 1'b0);
      check("rd_data_hold", m_if.rd_data, 32'h11BB33DD);
      read_check("strb_zero", 5, 1, 2);

      // asynchronous reset mid-cycle
      vict_check("vict_pre_rst", 5, 1);
      #3;
      resetn = 0;
      #1;
      check("async_rd_data", m_if.rd_data, 32'h0);
      check("async_vict_line", m_if.vict_line, '0);
      check("async_busy", m_if.refill_busy, 1'b0);
      @(posedge clk);
      #1;
      resetn = 1;
      tick();
      check("async_wr_ready", m_if.wr_ready, 1'b1);
      read_check("array_survives_rst", 5, 1, 2);

      // known contents for the random region and the refill test
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < WAYS; w++)
            for (int o = 0; o < WORDS; o++) write_word(s, w, o, $urandom);
      write_word(9, 0, 1, 32'h5555AAAA);
      write_word(9, 1, 0, 32'h0BADF00D);

      // refill of set 9 way 0 with one gap; store in the start cycle is accepted
      m_if.refill_start = 1; m_if.refill_index = 8'd9; m_if.refill_way = 1'b0;
      set_wr(9, 1, 3, 4'hF, 32'h12345678);
      tick();
      ref_mem[lin(9, 1, 3)] = 32'h12345678;
      m_if.refill_start = 0;
      check("refill_busy_rise", m_if.refill_busy, 1'b1);
      check("refill_wr_ready", m_if.wr_ready, 1'b0);
      check("refill_no_early_done", m_if.refill_done, 1'b0);
      beat = 0;
      for (int slot = 0; slot < 5; slot++) begin
         logic gap;
         gap = (slot == 2);
         m_if.refill_valid = !gap;
         m_if.refill_data = gap ? 32'hDEAD0000 : 32'hA0 + 32'(beat);
         set_wr(9, 1, 0, 4'hF, 32'hDEADBEEF);
         m_if.rd_en = 0;
         if (beat == 1 && !gap) set_rd(9, 0, 1);
         exp_rd = FWD ? 32'hA1 : ref_mem[lin(9, 0, 1)];
         tick();
         if (m_if.rd_en) check("refill_collide_rd", m_if.rd_data, exp_rd);
         if (!gap) begin
            ref_mem[lin(9, 0, beat)] = 32'hA0 + 32'(beat);
            beat++;
         end
         check("refill_done", m_if.refill_done, beat == WORDS);
         check("refill_busy", m_if.refill_busy, beat != WORDS);
         check("refill_wr_ready_hold", m_if.wr_ready, beat == WORDS);
      end
      m_idle();
      tick();
      check("refill_done_once", m_if.refill_done, 1'b0);
      vict_check("refill_line", 9, 0);
      check("refill_line_const", m_if.vict_line[127:0], {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      read_check("store_dropped_in_refill", 9, 1, 0);
      read_check("store_with_start", 9, 1, 3);

      // same-cycle store/load/victim collision
      for (int o = 0; o < WORDS; o++) write_word(20, 0, o, 32'h0 + 32'(o));
      write_word(20, 0, 3, 32'h0);
      set_wr(20, 0, 3, 4'hF, 32'hFFFFFFFF);
      set_rd(20, 0, 3);
      m_if.vict_req = 1; m_if.vict_index = 8'd20; m_if.vict_way = 1'b0;
      exp_v = model_line(20, 0);
      if (FWD) exp_v[127:96] = 32'hFFFFFFFF;
      tick();
      m_idle();
      check("collide_rd", m_if.rd_data, FWD ? 32'hFFFFFFFF : 32'h0);
      check("collide_vict", m_if.vict_line, exp_v);
      ref_mem[lin(20, 0, 3)] = 32'hFFFFFFFF;
      set_wr(20, 0, 3, 4'b0011, 32'h12345678);
      set_rd(20, 0, 3);
      tick();
      m_idle();
      check("collide_partial", m_if.rd_data, FWD ? 32'hFFFF5678 : 32'hFFFFFFFF);
      ref_mem[lin(20, 0, 3)] = 32'hFFFF5678;
      read_check("collide_after", 20, 0, 3);

      // randomized traffic over sets 0..3
      read_check("rnd_seed_rd", 0, 0, 0);
      last_rd = ref_mem[lin(0, 0, 0)];
      for (int i = 0; i < 200; i++) begin
         int ws, ww, wo, rs, rw, ro, vs, vw;
         bit do_wr, do_rd, do_v;
         logic [3:0]  strb;
         logic [31:0] wd, word;
         ws = $urandom_range(0, 3); ww = $urandom_range(0, 1); wo = $urandom_range(0, 3);
         rs = $urandom_range(0, 3); rw = $urandom_range(0, 1); ro = $urandom_range(0, 3);
         vs = $urandom_range(0, 3); vw = $urandom_range(0, 1);
         if ($urandom_range(0, 2) == 0) begin rs = ws; rw = ww; ro = wo; end
         if ($urandom_range(0, 2) == 0) begin vs = ws; vw = ww; end
         do_wr = $urandom_range(0, 1) == 1;
         do_rd = $urandom_range(0, 1) == 1;
         do_v  = $urandom_range(0, 3) == 0;
         strb = 4'($urandom);
         wd = $urandom;
         exp_rd = ref_mem[lin(rs, rw, ro)];
         if (FWD && do_wr && lin(ws, ww, wo) == lin(rs, rw, ro)) exp_rd = apply_strb(exp_rd, wd, strb);
         exp_v = '0;
         for (int k = 0; k < WORDS; k++) begin
            word = ref_mem[lin(vs, vw, k)];
            if (FWD && do_wr && lin(ws, ww, wo) == lin(vs, vw, k)) word = apply_strb(word, wd, strb);
            exp_v[32*k +: 32] = word;
         end
         m_idle();
         if (do_wr) set_wr(ws, ww, wo, strb, wd);
         if (do_rd) set_rd(rs, rw, ro);
         if (do_v) begin
            m_if.vict_req = 1; m_if.vict_index = M_IDX_W'(vs); m_if.vict_way = M_WAY_W'(vw);
         end
         tick();
         if (do_wr) ref_mem[lin(ws, ww, wo)] = apply_strb(ref_mem[lin(ws, ww, wo)], wd, strb);
         check("rnd_rd_valid", m_if.rd_valid, do_rd);
         if (do_rd) begin
            check("rnd_rd", m_if.rd_data, exp_rd);
            last_rd = exp_rd;
         end else begin
            check("rnd_rd_hold", m_if.rd_data, last_rd);
         end
         check("rnd_vict_valid", m_if.vict_valid, do_v);
         if (do_v) check("rnd_vict", m_if.vict_line, exp_v);
      end
      m_idle();
      refill_line($urandom_range(0, 3), $urandom_range(0, 1), $urandom);

      // reset during refill after two beats
      m_if.refill_start = 1; m_if.refill_index = 8'd12; m_if.refill_way = 1'b1;
      tick();
      m_if.refill_start = 0;
      for (int k = 0; k < 2; k++) begin
         m_if.refill_valid = 1; m_if.refill_data = 32'hB0000000 + 32'(k);
         tick();
         ref_mem[lin(12, 1, k)] = 32'hB0000000 + 32'(k);
      end
      m_if.refill_valid = 0;
      #3;
      resetn = 0;
      #1;
      check("abort_busy", m_if.refill_busy, 1'b0);
      @(posedge clk);
      #1;
      resetn = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("abort_no_done", m_if.refill_done, 1'b0);
         check("abort_idle", m_if.refill_busy, 1'b0);
      end
      check("abort_wr_ready", m_if.wr_ready, 1'b1);
      read_check("abort_partial0", 12, 1, 0);
      read_check("abort_partial1", 12, 1, 1);
      refill_line(12, 1, 32'hC0000000);

      // alternate geometry: refill set 3 way 3, ignored start mid-refill
      g_if.refill_start = 1; g_if.refill_index = G_IDX_W'(3); g_if.refill_way = G_WAY_W'(3);
      tick();
      g_if.refill_start = 0;
      check("geo_busy_rise", g_if.refill_busy, 1'b1);
      exp_v = '0;
      for (int k = 0; k < G_WORDS; k++) begin
         logic [31:0] d;
         d = $urandom;
         exp_v[32*k +: 32] = d;
         g_if.refill_valid = 1; g_if.refill_data = d;
         g_if.refill_start = (k == 3);
         g_if.refill_index = '0; g_if.refill_way = '0;
         tick();
         g_if.refill_start = 0;
         check("geo_done", g_if.refill_done, k == G_WORDS - 1);
         check("geo_busy", g_if.refill_busy, k != G_WORDS - 1);
      end
      g_if.refill_valid = 0;
      g_if.vict_req = 1; g_if.vict_index = G_IDX_W'(3); g_if.vict_way = G_WAY_W'(3);
      tick();
      g_if.vict_req = 0;
      check("geo_done_pulse", g_if.refill_done, 1'b0);
      check("geo_vict_line", g_if.vict_line, exp_v);
      check("geo_vict_valid", g_if.vict_valid, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
